// File: rtl/register_scoreboard_pkg.sv
// Shared encodings and sizing constants for the register scoreboard.
// Optional statistics counters are enabled with SCOREBOARD_STATS_EN.
package register_scoreboard_pkg;

  localparam int MAX_LAT_DEF = 7;
  localparam int CNT_W       = $clog2(MAX_LAT_DEF + 1);
  localparam int NUM_UNITS   = 4;
  localparam int NUM_REGS    = 32;

  typedef enum logic [1:0] {
    UNIT_MISC = 2'd0,
    UNIT_ALU  = 2'd1,
    UNIT_MEM  = 2'd2,
    UNIT_FPU  = 2'd3
  } unit_e;

endpackage

// File: rtl/register_scoreboard_if.sv
// Decode-to-scoreboard issue interface: decoded operands in, accept/stall and
// per-register busy vectors out.
interface register_scoreboard_if;

  logic                          issue_valid;
  logic                          issue_ready;
  logic [4:0]                    src1_addr;
  logic                          src1_float;
  logic                          src1_used;
  logic [4:0]                    src2_addr;
  logic                          src2_float;
  logic                          src2_used;
  logic [4:0]                    dst_addr;
  logic                          dst_float;
  logic                          dst_used;
  register_scoreboard_pkg::unit_e dst_unit;
  logic [2:0]                    dst_latency;
  logic                          stall;
  logic [31:0]                   busy_int;
  logic [31:0]                   busy_float;

  modport master (
    output issue_valid, src1_addr, src1_float, src1_used,
           src2_addr, src2_float, src2_used,
           dst_addr, dst_float, dst_used, dst_unit, dst_latency,
    input  issue_ready, stall, busy_int, busy_float
  );

  modport slave (
    input  issue_valid, src1_addr, src1_float, src1_used,
           src2_addr, src2_float, src2_used,
           dst_addr, dst_float, dst_used, dst_unit, dst_latency,
    output issue_ready, stall, busy_int, busy_float
  );

endinterface

// File: rtl/register_scoreboard_write_port_slots.sv
// Per-unit write-port reservation vector. Bit k of the shifted view means the
// port is busy k+1 cycles after the current one.
module write_port_slots
  import register_scoreboard_pkg::*;
#(
  parameter int MAX_LAT = MAX_LAT_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             reserve,
  input  logic [$clog2(MAX_LAT + 1)-1:0]   lat,
  output logic                             busy
);

  localparam int CW = $clog2(MAX_LAT + 1);

  logic [MAX_LAT-1:0] slots;
  logic [MAX_LAT-1:0] shifted;
  logic [MAX_LAT-1:0] sel;

  // Check and reservation both use the post-shift view so they line up with
  // the cycle the new result will actually occupy the port.
  always_comb begin
    shifted = slots >> 1;
    sel     = MAX_LAT'(1) << (lat - CW'(1));
    busy    = |(shifted & sel);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots <= '0;
    end else begin
      slots <= shifted | (reserve ? sel : '0);
    end
  end

endmodule

// File: rtl/register_scoreboard.sv
// Decode-stage RAW/WAW/write-port hazard tracker for the int and float files.
// Define SCOREBOARD_STATS_EN to add saturating per-cause stall counters.
module register_scoreboard
  import register_scoreboard_pkg::*;
#(
  parameter int MAX_LAT = MAX_LAT_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  register_scoreboard_if.slave  sb
`ifdef SCOREBOARD_STATS_EN
  ,
  output logic [31:0]           raw_stall_count,
  output logic [31:0]           waw_stall_count,
  output logic [31:0]           port_stall_count
`endif
);

  localparam int CW = $clog2(MAX_LAT + 1);

  function automatic logic [CW-1:0] sat_latency(input logic [2:0] l);
    if (l == 3'd0)        return CW'(1);
    if (int'(l) > MAX_LAT) return CW'(MAX_LAT);
    return CW'(l);
  endfunction

  function automatic logic is_int_zero(input logic is_float, input logic [4:0] addr);
    return !is_float && (addr == 5'd0);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

  logic [CW-1:0]        cnt_int   [NUM_REGS];
  logic [CW-1:0]        cnt_float [NUM_REGS];
  logic [CW-1:0]        lat;
  logic [CW-1:0]        s1_cnt, s2_cnt, d_cnt;
  logic                 raw_hz, waw_hz, port_hz, hazard;
  logic                 accept, wr_en;
  logic [NUM_UNITS-1:0] port_busy;
  logic [31:0]          busy_int_w, busy_float_w;

  always_comb begin
    lat     = sat_latency(sb.dst_latency);
    s1_cnt  = sb.src1_float ? cnt_float[sb.src1_addr] : cnt_int[sb.src1_addr];
    s2_cnt  = sb.src2_float ? cnt_float[sb.src2_addr] : cnt_int[sb.src2_addr];
    d_cnt   = sb.dst_float  ? cnt_float[sb.dst_addr]  : cnt_int[sb.dst_addr];
    // cnt == 1 is covered by forwarding, so only counts above 1 block a read.
    raw_hz  = (sb.src1_used && !is_int_zero(sb.src1_float, sb.src1_addr) && (s1_cnt > CW'(1)))
           || (sb.src2_used && !is_int_zero(sb.src2_float, sb.src2_addr) && (s2_cnt > CW'(1)));
    waw_hz  = sb.dst_used && !is_int_zero(sb.dst_float, sb.dst_addr)
           && (d_cnt != '0) && (d_cnt >= lat);
    port_hz = sb.dst_used && port_busy[sb.dst_unit];
    hazard  = raw_hz || waw_hz || port_hz;
    accept  = sb.issue_valid && !hazard;
    wr_en   = accept && sb.dst_used;
  end

  assign sb.issue_ready = accept;
  assign sb.stall       = sb.issue_valid && hazard;
  assign sb.busy_int    = busy_int_w;
  assign sb.busy_float  = busy_float_w;

  for (genvar u = 0; u < NUM_UNITS; u++) begin : g_port
    write_port_slots #(.MAX_LAT(MAX_LAT)) u_slots (
      .clk     (clk),
      .rst_n   (rst_n),
      .reserve (wr_en && (sb.dst_unit == unit_e'(u))),
      .lat     (lat),
      .busy    (port_busy[u])
    );
  end

  // A new reservation overrides the decrement of the same register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_int[i]   <= '0;
        cnt_float[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && !sb.dst_float && (sb.dst_addr == 5'(i)) && (i != 0))
          cnt_int[i] <= lat;
        else if (cnt_int[i] != '0)
          cnt_int[i] <= cnt_int[i] - CW'(1);

        if (wr_en && sb.dst_float && (sb.dst_addr == 5'(i)))
          cnt_float[i] <= lat;
        else if (cnt_float[i] != '0)
          cnt_float[i] <= cnt_float[i] - CW'(1);
      end
    end
  end

  always_comb begin
    busy_int_w   = '0;
    busy_float_w = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_int_w[i]   = (cnt_int[i] != '0);
      busy_float_w[i] = (cnt_float[i] != '0);
    end
  end

`ifdef SCOREBOARD_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      raw_stall_count  <= '0;
      waw_stall_count  <= '0;
      port_stall_count <= '0;
    end else if (sb.issue_valid && hazard) begin
      if (raw_hz)  raw_stall_count  <= sat_inc(raw_stall_count);
      if (waw_hz)  waw_stall_count  <= sat_inc(waw_stall_count);
      if (port_hz) port_stall_count <= sat_inc(port_stall_count);
    end
  end
`endif

endmodule

// File: tb/tb_register_scoreboard.sv
// Directed bench for register_scoreboard: per-instruction expected stall
// counts are queued by the driver and checked by a monitor on acceptance.
module tb_register_scoreboard;
  import register_scoreboard_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  register_scoreboard_if sb_if ();

`ifdef SCOREBOARD_STATS_EN
  logic [31:0] raw_cnt, waw_cnt, port_cnt;
`endif

  register_scoreboard dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sb    (sb_if)
`ifdef SCOREBOARD_STATS_EN
    ,
    .raw_stall_count  (raw_cnt),
    .waw_stall_count  (waw_cnt),
    .port_stall_count (port_cnt)
`endif
  );

  int    tests = 0;
  int    fails = 0;
  int    exp_q [$];
  string name_q[$];
  int    stall_run = 0;

  // Monitor: count stall cycles of the presented instruction, compare on accept.
  always @(negedge clk) begin
    int    e;
    string n;
    if (rst_n && sb_if.issue_valid) begin
      if (sb_if.stall) stall_run++;
      if (sb_if.issue_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_accept: got accept, want none queued");
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          if (stall_run != e) begin
            fails++;
            $display("FAIL %s: stall cycles got %0d want %0d", n, stall_run, e);
          end
        end
        stall_run = 0;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, got, want);
    end
  endtask

  task automatic clear_ins();
    sb_if.issue_valid = 1'b0;
    sb_if.src1_addr = '0; sb_if.src1_float = 1'b0; sb_if.src1_used = 1'b0;
    sb_if.src2_addr = '0; sb_if.src2_float = 1'b0; sb_if.src2_used = 1'b0;
    sb_if.dst_addr  = '0; sb_if.dst_float  = 1'b0; sb_if.dst_used  = 1'b0;
    sb_if.dst_unit  = UNIT_MISC; sb_if.dst_latency = '0;
  endtask

  task automatic set_wr(input unit_e u, input logic f, input logic [4:0] a, input logic [2:0] l);
    sb_if.dst_used = 1'b1; sb_if.dst_unit = u; sb_if.dst_float = f;
    sb_if.dst_addr = a;    sb_if.dst_latency = l;
  endtask

  task automatic set_rd1(input logic f, input logic [4:0] a);
    sb_if.src1_used = 1'b1; sb_if.src1_float = f; sb_if.src1_addr = a;
  endtask

  // Present the staged instruction until accepted (bounded), then drop it.
  task automatic send(input string nm, input int exp_stalls);
    bit ok;
    exp_q.push_back(exp_stalls);
    name_q.push_back(nm);
    sb_if.issue_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (sb_if.issue_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s: not accepted within 20 cycles, want %0d stalls", nm, exp_stalls);
      void'(exp_q.pop_back());
      void'(name_q.pop_back());
      stall_run = 0;
    end
    clear_ins();
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_ins();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("reset_busy_int",   64'(sb_if.busy_int),   64'd0);
    chk("reset_busy_float", 64'(sb_if.busy_float), 64'd0);
    chk("reset_stall",      64'(sb_if.stall),      64'd0);
    chk("reset_ready",      64'(sb_if.issue_ready), 64'd0);
    @(posedge clk);
    #1;

    set_rd1(1'b0, 5'd5);                       send("read_r5", 0);

    // RAW on f3 (L=4); an int r3 read in between is not affected.
    set_wr(UNIT_FPU, 1'b1, 5'd3, 3'd4);        send("wr_f3_l4", 0);
    chk("busy_float3", 64'(sb_if.busy_float[3]), 64'd1);
    chk("busy_int3",   64'(sb_if.busy_int[3]),   64'd0);
    set_rd1(1'b0, 5'd3);                       send("read_r3", 0);
    set_rd1(1'b1, 5'd3);                       send("raw_f3", 2);
`ifdef SCOREBOARD_STATS_EN
    chk("stats_raw",  64'(raw_cnt),  64'd2);
    chk("stats_waw",  64'(waw_cnt),  64'd0);
    chk("stats_port", 64'(port_cnt), 64'd0);
`endif
    idle(6);

    // WAW on r7: mem L=3, one gap, then alu L=1 waits for cnt 2 and 1.
    set_wr(UNIT_MEM, 1'b0, 5'd7, 3'd3);        send("wr_r7_l3", 0);
    idle(1);
    set_wr(UNIT_ALU, 1'b0, 5'd7, 3'd1);        send("waw_r7", 2);
    chk("busy_int7_set", 64'(sb_if.busy_int[7]), 64'd1);
    idle(1);
    chk("busy_int7_clr", 64'(sb_if.busy_int[7]), 64'd0);
    idle(6);

    // Latency 0 behaves as 1; an L=1 rewrite must wait out cnt == 1.
    set_wr(UNIT_ALU, 1'b0, 5'd9, 3'd0);        send("wr_r9_l0", 0);
    set_wr(UNIT_ALU, 1'b0, 5'd9, 3'd1);        send("waw_r9_l1", 1);
    set_rd1(1'b0, 5'd9);                       send("read_r9_fwd", 0);
    idle(6);

    // Port conflict on the fpu port.
    set_wr(UNIT_FPU, 1'b1, 5'd1, 3'd3);        send("wr_f1_l3", 0);
    set_wr(UNIT_FPU, 1'b1, 5'd2, 3'd2);        send("port_f2_l2", 1);
    idle(6);

    // Int r0 is never tracked.
    set_wr(UNIT_ALU, 1'b0, 5'd0, 3'd2);        send("wr_r0_l2", 0);
    chk("busy_int0", 64'(sb_if.busy_int[0]), 64'd0);
    set_rd1(1'b0, 5'd0);                       send("read_r0", 0);
    idle(6);

    // Float f0 is tracked normally.
    set_wr(UNIT_FPU, 1'b1, 5'd0, 3'd3);        send("wr_f0_l3", 0);
    set_rd1(1'b1, 5'd0);                       send("raw_f0", 2);
    idle(6);

    // Reset in the middle of tracking discards everything.
    set_wr(UNIT_ALU, 1'b0, 5'd10, 3'd7);       send("wr_r10_l7", 0);
    chk("busy_int10", 64'(sb_if.busy_int[10]), 64'd1);
    rst_n = 1'b0;
    #2;
    chk("midreset_busy_int", 64'(sb_if.busy_int), 64'd0);
`ifdef SCOREBOARD_STATS_EN
    chk("midreset_stats_raw", 64'(raw_cnt), 64'd0);
`endif
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_rd1(1'b0, 5'd10);                      send("read_r10_after_rst", 0);
    idle(2);

    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
